// File: rtl/tlb_walk_arb.sv
// Arbitrates the shared page-table walker between the I-TLB and D-TLB miss ports.
// Optional walk/fault statistics counters are built only when TLB_WALK_STATS_EN is defined.
package tlb_walk_arb_pkg;
  typedef struct packed {
    logic [43:0] ppn;
    logic [1:0]  pgsize;
    logic        fault;
  } page_walk_rsp_t;
endpackage

module tlb_walk_arb
  import tlb_walk_arb_pkg::*;
#(
  parameter int VA_W    = 64,
  parameter int D_FIRST = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            itlb_miss,
  input  logic [VA_W-1:0] itlb_miss_va,
  input  logic            dtlb_miss,
  input  logic [VA_W-1:0] dtlb_miss_va,
  output logic            walk_req,
  output logic [VA_W-1:0] walk_va,
  input  logic            walk_rdy,
  input  logic            walk_rsp_valid,
  input  page_walk_rsp_t  walk_rsp,
  output logic            itlb_replace,
  output logic            dtlb_replace,
  output logic [VA_W-1:0] replace_va,
  output page_walk_rsp_t  page_walk_rsp,
  output logic            busy,
  output logic [63:0]     walk_count,
  output logic [63:0]     fault_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic            r_side;          // 1 = D-side, 0 = I-side
  logic            r_last_grant;
  logic            r_flushed;
  logic [1:0]      served_mask;     // bit 1 = D-side, bit 0 = I-side
  logic [VA_W-1:0] r_va;

  logic elig_i, elig_d, contended, grant_side, grant, replace_ok;

  assign elig_i     = itlb_miss & ~served_mask[0];
  assign elig_d     = dtlb_miss & ~served_mask[1];
  assign contended  = elig_i & elig_d;
  assign grant_side = contended ? ~r_last_grant : elig_d;
  assign grant      = (state == IDLE) && (state_next == REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      r_side        <= 1'b0;
      r_va          <= '0;
      r_last_grant  <= (D_FIRST == 0);
      r_flushed     <= 1'b0;
      served_mask   <= 2'b00;
      page_walk_rsp <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        r_side <= grant_side;
        r_va   <= grant_side ? dtlb_miss_va : itlb_miss_va;
        if (contended) r_last_grant <= grant_side;
      end
      // Hide the just-served side for one IDLE cycle while its miss line falls.
      if (state == RESP) served_mask <= r_side ? 2'b10 : 2'b01;
      else if (state == IDLE) served_mask <= 2'b00;
      if (state == WAIT) begin
        if (walk_rsp_valid) r_flushed <= 1'b0;
        else if (flush) r_flushed <= 1'b1;
      end
      if (state == WAIT && walk_rsp_valid && !r_flushed && !flush)
        page_walk_rsp <= walk_rsp;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!flush && (elig_i || elig_d)) state_next = REQ;
      REQ: begin
        if (flush) state_next = IDLE;
        else if (walk_rdy) state_next = WAIT;
      end
      WAIT: if (walk_rsp_valid) state_next = (r_flushed || flush) ? IDLE : RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    walk_req     = (state == REQ);
    walk_va      = (state == REQ) ? r_va : '0;
    replace_ok   = (state == RESP) && !flush;
    itlb_replace = replace_ok & ~r_side;
    dtlb_replace = replace_ok & r_side;
    replace_va   = (state == RESP) ? r_va : '0;
    busy         = (state != IDLE);
  end

`ifdef TLB_WALK_STATS_EN
  logic [63:0] walk_count_reg, fault_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      walk_count_reg  <= '0;
      fault_count_reg <= '0;
    end else if (replace_ok) begin
      walk_count_reg <= walk_count_reg + 64'd1;
      if (page_walk_rsp.fault) fault_count_reg <= fault_count_reg + 64'd1;
    end
  end

  assign walk_count  = walk_count_reg;
  assign fault_count = fault_count_reg;
`else
  assign walk_count  = '0;
  assign fault_count = '0;
`endif

endmodule

// File: tb/tb_tlb_walk_arb.sv
// Randomized scoreboard bench for tlb_walk_arb: the bench plays both TLB requesters and the walker.
`timescale 1ns/1ps
module tb_tlb_walk_arb;
  import tlb_walk_arb_pkg::*;

  localparam int VA_W    = 64;
  localparam int D_FIRST = 1;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic            itlb_miss, dtlb_miss;
  logic [VA_W-1:0] itlb_miss_va, dtlb_miss_va;
  logic            walk_req, walk_rdy, walk_rsp_valid;
  logic [VA_W-1:0] walk_va, replace_va;
  page_walk_rsp_t  walk_rsp, page_walk_rsp;
  logic            itlb_replace, dtlb_replace, busy;
  logic [63:0]     walk_count, fault_count;

  tlb_walk_arb #(.VA_W(VA_W), .D_FIRST(D_FIRST)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .itlb_miss(itlb_miss), .itlb_miss_va(itlb_miss_va),
    .dtlb_miss(dtlb_miss), .dtlb_miss_va(dtlb_miss_va),
    .walk_req(walk_req), .walk_va(walk_va), .walk_rdy(walk_rdy),
    .walk_rsp_valid(walk_rsp_valid), .walk_rsp(walk_rsp),
    .itlb_replace(itlb_replace), .dtlb_replace(dtlb_replace),
    .replace_va(replace_va), .page_walk_rsp(page_walk_rsp),
    .busy(busy), .walk_count(walk_count), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            side;
    logic [VA_W-1:0] va;
    page_walk_rsp_t  rsp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: which sides have an outstanding miss and who won the last tie.
  bit              m_pend [2];
  logic [VA_W-1:0] m_va   [2];
  bit              m_last;
  int              m_walks, m_faults;
  int              drop_i, drop_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, expv);
    end
  endtask

  function automatic void model_reset();
    m_pend[0] = 0; m_pend[1] = 0;
    // The first tie goes to the D_FIRST side, so "last winner" starts as the other one.
    m_last   = (D_FIRST != 0) ? 1'b0 : 1'b1;
    m_walks  = 0;
    m_faults = 0;
  endfunction

  function automatic int model_grant();
    int g;
    if (m_pend[0] && m_pend[1]) begin
      g = m_last ? 0 : 1;
      m_last = g[0];
    end else begin
      g = m_pend[1] ? 1 : 0;
    end
    return g;
  endfunction

  // One clock step; requesters drop their miss one full cycle after seeing their replace.
  task automatic tick();
    @(negedge clk);
    if (drop_i > 0) begin drop_i--; if (drop_i == 0) itlb_miss = 1'b0; end
    if (drop_d > 0) begin drop_d--; if (drop_d == 0) dtlb_miss = 1'b0; end
    if (itlb_replace) drop_i = 2;
    if (dtlb_replace) drop_d = 2;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (itlb_replace || dtlb_replace) begin
        if (exp_q.size() == 0) begin
          chk("replace_unexpected", {62'd0, itlb_replace, dtlb_replace}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("replace_side", {62'd0, itlb_replace, dtlb_replace}, e.side ? 64'd1 : 64'd2);
          chk("replace_va", replace_va, e.va);
          chk("page_walk_rsp", {17'd0, page_walk_rsp}, {17'd0, e.rsp});
          $display("replace side=%s va=%h fault=%0d pgsize=%0d",
                   e.side ? "D" : "I", e.va, e.rsp.fault, e.rsp.pgsize);
        end
      end
    end
  endtask

  function automatic page_walk_rsp_t rand_rsp(input bit force_fault);
    page_walk_rsp_t r;
    r.ppn    = {$urandom(), $urandom()};
    r.pgsize = 2'($urandom_range(0, 3));
    r.fault  = force_fault | ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  // fmode: -1 random flushes, 0 none, 1 flush in REQ on first walk, 2 flush in WAIT on first walk.
  task automatic run_scenario(input bit ri, input bit rd, input int fmode, input bit ffault);
    int g, waited, d, r, fpos;
    bit fr, fw, first;
    page_walk_rsp_t rsp;
    exp_t e;
    if (ri) begin itlb_miss_va = {$urandom(), $urandom()}; itlb_miss = 1'b1; m_pend[0] = 1; m_va[0] = itlb_miss_va; end
    if (rd) begin dtlb_miss_va = {$urandom(), $urandom()}; dtlb_miss = 1'b1; m_pend[1] = 1; m_va[1] = dtlb_miss_va; end
    first = 1;
    while (m_pend[0] || m_pend[1]) begin
      waited = 0;
      while (!walk_req && waited < 20) begin tick(); waited++; end
      if (!walk_req) begin
        chk("walk_req_timeout", {63'd0, walk_req}, 64'd1);
        return;
      end
      g = model_grant();
      chk("walk_va", walk_va, m_va[g]);
      fr = 0; fw = 0;
      if (first && fmode >= 0) begin
        fr = (fmode == 1); fw = (fmode == 2);
      end else if (fmode < 0) begin
        fr = ($urandom_range(0, 7) == 0);
        fw = !fr && ($urandom_range(0, 5) == 0);
      end
      first = 0;
      d = $urandom_range(0, 2);
      repeat (d) tick();
      chk("walk_req_held", {63'd0, walk_req}, 64'd1);
      walk_rdy = 1'b1; flush = fr;
      tick();
      walk_rdy = 1'b0; flush = 1'b0;
      if (fr) begin
        chk("flush_req_idle", {62'd0, busy, walk_req}, 64'd0);
        continue;
      end
      r    = $urandom_range(0, 3);
      fpos = $urandom_range(0, r);
      for (int i = 0; i <= r; i++) begin
        flush = fw && (i == fpos);
        walk_rsp_valid = (i == r);
        if (i == r) begin
          rsp = rand_rsp(ffault);
          walk_rsp = rsp;
          if (!fw) begin
            e.side = g[0]; e.va = m_va[g]; e.rsp = rsp;
            exp_q.push_back(e);
          end
        end
        tick();
      end
      walk_rsp_valid = 1'b0; flush = 1'b0;
      walk_rsp = rand_rsp(1'b0);
      if (fw) begin
        chk("discard_idle", {63'd0, busy}, 64'd0);
      end else begin
        m_pend[g] = 0;
        m_walks++;
        if (rsp.fault) m_faults++;
      end
    end
    repeat (4) tick();
    chk("no_extra_walk", {62'd0, walk_req, busy}, 64'd0);
  endtask

  task automatic check_stats();
`ifdef TLB_WALK_STATS_EN
    chk("walk_count", walk_count, 64'(m_walks));
    chk("fault_count", fault_count, 64'(m_faults));
`else
    chk("walk_count_tied", walk_count, 64'd0);
    chk("fault_count_tied", fault_count, 64'd0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ctrl"}, {60'd0, walk_req, itlb_replace, dtlb_replace, busy}, 64'd0);
    chk({tag, "_walk_va"}, walk_va, 64'd0);
    chk({tag, "_replace_va"}, replace_va, 64'd0);
    chk({tag, "_page_walk_rsp"}, {17'd0, page_walk_rsp}, 64'd0);
  endtask

  initial begin
    exp_t e;
    int waited;
    reset = 1'b1; flush = 1'b0; walk_rdy = 1'b0; walk_rsp_valid = 1'b0;
    itlb_miss = 1'b0; dtlb_miss = 1'b0; itlb_miss_va = '0; dtlb_miss_va = '0;
    walk_rsp = '0; drop_i = 0; drop_d = 0;
    model_reset();
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) tick();
    reset = 1'b0;
    check_idle_outputs("reset");
    chk("reset_counts", walk_count | fault_count, 64'd0);

    // Directed D-side walk with the exact cycle timing of a single miss.
    tick();
    dtlb_miss_va = 64'h8000_1000; dtlb_miss = 1'b1; m_pend[1] = 1; m_va[1] = dtlb_miss_va;
    tick();
    chk("t1_walk_req_c1", {63'd0, walk_req}, 64'd1);
    chk("t1_walk_va", walk_va, m_va[model_grant()]);
    tick();
    chk("t1_walk_req_c2", {63'd0, walk_req}, 64'd1);
    walk_rdy = 1'b1;
    tick();
    walk_rdy = 1'b0;
    chk("t1_walk_req_c3", {62'd0, walk_req, busy}, 64'd1);
    tick();
    tick();
    walk_rsp = '{ppn: 44'h123, pgsize: 2'd2, fault: 1'b0};
    walk_rsp_valid = 1'b1;
    e.side = 1'b1; e.va = 64'h8000_1000; e.rsp = walk_rsp;
    exp_q.push_back(e);
    chk("t1_no_early_replace", {62'd0, itlb_replace, dtlb_replace}, 64'd0);
    tick();
    walk_rsp_valid = 1'b0;
    chk("t1_replace_c6", {62'd0, itlb_replace, dtlb_replace}, 64'd1);
    m_pend[1] = 0; m_walks++;
    tick();
    chk("t1_replace_c7", {62'd0, itlb_replace, dtlb_replace}, 64'd0);
    repeat (4) tick();

    // Contended start: D_FIRST side first, then the other.
    run_scenario(1, 1, 0, 0);
    run_scenario(1, 1, 0, 0);
    run_scenario(0, 1, 2, 0);
    run_scenario(1, 0, 1, 0);
    run_scenario(1, 1, 1, 0);
    run_scenario(1, 0, 0, 1);
    check_stats();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: run_scenario(1, 0, -1, 0);
        1: run_scenario(0, 1, -1, 0);
        default: run_scenario(1, 1, -1, 0);
      endcase
    end
    check_stats();

    // Reset while the walker owes a response; the late response must be ignored.
    dtlb_miss_va = {$urandom(), $urandom()}; dtlb_miss = 1'b1;
    waited = 0;
    while (!walk_req && waited < 20) begin tick(); waited++; end
    chk("rst_walk_va", walk_va, dtlb_miss_va);
    walk_rdy = 1'b1;
    tick();
    walk_rdy = 1'b0;
    chk("rst_in_wait", {63'd0, busy}, 64'd1);
    reset = 1'b1; dtlb_miss = 1'b0; drop_d = 0;
    tick();
    reset = 1'b0;
    model_reset();
    check_idle_outputs("midreset");
    check_stats();
    walk_rsp = rand_rsp(1'b0);
    walk_rsp_valid = 1'b1;
    tick();
    walk_rsp_valid = 1'b0;
    check_idle_outputs("stray_rsp");
    tick();
    chk("stray_rsp_later", {61'd0, itlb_replace, dtlb_replace, busy}, 64'd0);

    // After reset the tie-break restarts from the D_FIRST side.
    run_scenario(1, 1, 0, 0);
    check_stats();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_walk_arb.md
Name: tlb_walk_arb

Overview:
- Shares the single page-table walker between the I-side and D-side TLBs.
- Accepts level-held miss requests and grants one at a time (round-robin when both are pending).
- Sequences the walker request/response handshake and returns the walk result to the missing TLB as a one-cycle replace pulse with replace_va.
- Handles TLB clear (sfence/satp write) arriving mid-walk by discarding the stale result.

Parameters:
- VA_W, 64, width of miss and replace virtual addresses.
- D_FIRST, 1, winner when both sides request from reset state (1 = D-side, 0 = I-side).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- flush  input  1  TLB clear; same signal that drives the TLBs' clear
- itlb_miss  input  1  I-TLB miss pending (held until itlb_replace seen)
- itlb_miss_va  input  VA_W  I-side missing VA
- dtlb_miss  input  1  D-TLB miss pending (held until dtlb_replace seen)
- dtlb_miss_va  input  VA_W  D-side missing VA
- walk_req  output  1  request to walker
- walk_va  output  VA_W  VA to walk, stable while walk_req=1
- walk_rdy  input  1  walker accepts request this cycle
- walk_rsp_valid  input  1  walker result valid (one cycle)
- walk_rsp  input  page_walk_rsp_t  walker result
- itlb_replace  output  1  replace pulse to I-TLB
- dtlb_replace  output  1  replace pulse to D-TLB
- replace_va  output  VA_W  VA for the replacing TLB
- page_walk_rsp  output  page_walk_rsp_t  registered walk result for the TLBs
- busy  output  1  state != IDLE
- walk_count  output  64  completed walks (optional feature)
- fault_count  output  64  faulting walks (optional feature)

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset (synchronous, active-high) -> IDLE.
- Reset values: all outputs 0; r_last_grant set so the first contended grant goes to D_FIRST's side; r_flushed=0; served-mask=0.
- IDLE:
  - Eligible sides are those with miss=1 and not masked.
  - None eligible, or flush=1 -> stay in IDLE.
  - One eligible -> grant it.
  - Both eligible -> grant the side opposite r_last_grant, then update r_last_grant.
  - On grant: latch side and VA into r_side/r_va, go to REQ.
- REQ:
  - walk_req=1, walk_va=r_va.
  - flush=1 -> IDLE; the request is dropped, flush has priority over walk_rdy, and the walker must ignore a walk_rdy in that cycle.
  - Otherwise walk_rdy=1 -> WAIT.
- WAIT:
  - walk_req=0. flush=1 sets r_flushed.
  - On walk_rsp_valid:
    - If r_flushed or flush -> discard, clear r_flushed, go to IDLE with no replace.
    - Otherwise register walk_rsp into page_walk_rsp and go to RESP.
- RESP:
  - Exactly one cycle. The r_side replace output = 1 with replace_va=r_va and page_walk_rsp held.
  - flush=1 in this cycle suppresses the replace (both outputs 0).
  - Set the served-mask for r_side, then go to IDLE.
- Served-mask: masks the just-served side for exactly one IDLE cycle, covering the requester's one-cycle miss deassert latency. Cleared after that cycle.
- Faulting walks still pulse replace. The TLB itself skips the write on page_walk_rsp.fault; the requester sees the fault via page_walk_rsp.
- Latency:
  - Miss seen in IDLE at cycle t -> walk_req at t+1.
  - walk_rsp_valid at cycle k -> replace at k+1.
- walk_rsp_valid outside WAIT is ignored.
- A miss arriving during a walk waits; it is not lost because misses are level-held.
- Flush in IDLE blocks a grant that cycle only.
- reset mid-walk -> IDLE immediately; a later stray walk_rsp_valid is ignored.

Optional Feature:
- TLB_WALK_STATS_EN defined:
  - walk_count increments (64-bit, wraps) on every RESP cycle that is not suppressed.
  - fault_count increments on the same cycles when page_walk_rsp.fault=1.
  - Both counters reset to 0.
- Not defined: both ports tied to 0, and no counter flops are inferred.

Test Plan:
- dtlb_miss=1, va=0x80001000 at t=0; walk_rdy=1 at t=2; rsp_valid at t=5 (fault=0, pgsize=2) -> walk_req t=1..2, walk_va=0x80001000, dtlb_replace=1 only at t=6, replace_va=0x80001000, itlb_replace=0.
- From reset, itlb_miss and dtlb_miss asserted together at t=0, each dropped the cycle after its replace -> D walk first, then I walk. Repeat with both held -> grants alternate I/D; no side is granted twice consecutively while the other is pending.
- flush=1 during WAIT, rsp_valid 3 cycles later -> no replace pulse, busy=0 the cycle after rsp, next miss regranted normally.
- flush=1 in REQ with walk_rdy=1 the same cycle -> IDLE next cycle, no WAIT, no replace.
- rsp with fault=1 -> replace pulses with page_walk_rsp.fault=1. With TLB_WALK_STATS_EN: walk_count=1, fault_count=1; without it, both counters read 0.
- reset asserted in WAIT, then rsp_valid=1 -> all outputs 0, state IDLE, no replace.
